// File: rtl/qp_mem_loader.sv
// qp_mem_loader
//   Owns the single port of the query-patch SRAM. In normal operation it
//   streams NUM_QUERYS patches into consecutive SRAM addresses, then serves
//   pipelined single-cycle-issue reads to the search datapath. When
//   wbs_debug is high, the Wishbone controller's SRAM signals pass straight
//   through and all internal traffic is stalled.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wbs_debug             debug override from the Wishbone controller
//   wbs_qp_mem_*          debug SRAM port (csb/web active low); rpatch0 is
//                         the raw SRAM read data
//   load_start            pulse that starts or restarts a load
//   patch_valid/ready/in  query-patch stream
//   load_done             all NUM_QUERYS patches written
//   rd_req/rd_addr        accelerator read request
//   rd_valid/rd_patch     accelerator read response, one cycle after issue
//   mem_*                 SRAM port (csb/web active low); mem_rpatch0 is
//                         valid the cycle after a read issue
module qp_mem_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int ROW_SIZE   = 24,
  parameter int COL_SIZE   = 17,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDRW      = $clog2(NUM_QUERYS),
  parameter int PW         = PATCH_SIZE * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             wbs_debug,
  input  logic             wbs_qp_mem_csb0,
  input  logic             wbs_qp_mem_web0,
  input  logic [ADDRW-1:0] wbs_qp_mem_addr0,
  input  logic [PW-1:0]    wbs_qp_mem_wpatch0,
  output logic [PW-1:0]    wbs_qp_mem_rpatch0,

  input  logic             load_start,
  input  logic             patch_valid,
  input  logic [PW-1:0]    patch_in,
  output logic             patch_ready,
  output logic             load_done,

  input  logic             rd_req,
  input  logic [ADDRW-1:0] rd_addr,
  output logic             rd_valid,
  output logic [PW-1:0]    rd_patch,

  output logic             mem_csb0,
  output logic             mem_web0,
  output logic [ADDRW-1:0] mem_addr0,
  output logic [PW-1:0]    mem_wpatch0,
  input  logic [PW-1:0]    mem_rpatch0
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NUM_QUERYS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [ADDRW-1:0] wr_cnt, wr_cnt_nxt;
  logic             load_done_nxt;
  logic             wr_fire;
  logic             rd_fire;

  assign patch_ready = (state == LOAD) & ~wbs_debug & ~load_start;
  assign wr_fire     = patch_valid & patch_ready;
  // Reads only outside LOAD, outside debug, and in range; anything else is
  // dropped without touching the SRAM.
  assign rd_fire     = rd_req & ~wbs_debug & (state != LOAD) & (rd_addr <= LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      load_done <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      load_done <= load_done_nxt;
      rd_valid  <= rd_fire;
    end
  end

  // Debug freezes the whole load context (including load_start) so the
  // stream resumes at the same address once the override is released.
  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    load_done_nxt = load_done;
    if (!wbs_debug) begin
      if (load_start) begin
        state_nxt     = LOAD;
        wr_cnt_nxt    = '0;
        load_done_nxt = 1'b0;
      end else if (wr_fire) begin
        if (wr_cnt == LAST_ADDR) begin
          state_nxt     = DONE;
          load_done_nxt = 1'b1;
        end else begin
          wr_cnt_nxt = wr_cnt + ADDRW'(1);
        end
      end
    end
  end

  // SRAM port mux: debug > load write > accelerator read > idle.
  always_comb begin
    mem_csb0    = 1'b1;
    mem_web0    = 1'b1;
    mem_addr0   = '0;
    mem_wpatch0 = '0;
    if (wbs_debug) begin
      mem_csb0    = wbs_qp_mem_csb0;
      mem_web0    = wbs_qp_mem_web0;
      mem_addr0   = wbs_qp_mem_addr0;
      mem_wpatch0 = wbs_qp_mem_wpatch0;
    end else if (wr_fire) begin
      mem_csb0    = 1'b0;
      mem_web0    = 1'b0;
      mem_addr0   = wr_cnt;
      mem_wpatch0 = patch_in;
    end else if (rd_fire) begin
      mem_csb0  = 1'b0;
      mem_addr0 = rd_addr;
    end
  end

  assign wbs_qp_mem_rpatch0 = mem_rpatch0;
  assign rd_patch           = rd_valid ? mem_rpatch0 : '0;

endmodule

// File: tb/tb_qp_mem_loader.sv
// tb_qp_mem_loader
//   Directed bench for qp_mem_loader with a behavioural single-port SRAM.
//   Inputs change 1 ns after the rising edge; outputs are sampled 2 ns
//   after the rising edge.
module tb_qp_mem_loader;

  localparam int NQ    = 408;
  localparam int ADDRW = 9;
  localparam int PW    = 55;
  localparam logic [PW-1:0] BEEF = 55'h001010DEADBEEF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wbs_debug;
  logic             wbs_qp_mem_csb0;
  logic             wbs_qp_mem_web0;
  logic [ADDRW-1:0] wbs_qp_mem_addr0;
  logic [PW-1:0]    wbs_qp_mem_wpatch0;
  logic [PW-1:0]    wbs_qp_mem_rpatch0;
  logic             load_start;
  logic             patch_valid;
  logic [PW-1:0]    patch_in;
  logic             patch_ready;
  logic             load_done;
  logic             rd_req;
  logic [ADDRW-1:0] rd_addr;
  logic             rd_valid;
  logic [PW-1:0]    rd_patch;
  logic             mem_csb0;
  logic             mem_web0;
  logic [ADDRW-1:0] mem_addr0;
  logic [PW-1:0]    mem_wpatch0;
  logic [PW-1:0]    mem_rpatch0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qp_mem_loader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wbs_debug          (wbs_debug),
    .wbs_qp_mem_csb0    (wbs_qp_mem_csb0),
    .wbs_qp_mem_web0    (wbs_qp_mem_web0),
    .wbs_qp_mem_addr0   (wbs_qp_mem_addr0),
    .wbs_qp_mem_wpatch0 (wbs_qp_mem_wpatch0),
    .wbs_qp_mem_rpatch0 (wbs_qp_mem_rpatch0),
    .load_start         (load_start),
    .patch_valid        (patch_valid),
    .patch_in           (patch_in),
    .patch_ready        (patch_ready),
    .load_done          (load_done),
    .rd_req             (rd_req),
    .rd_addr            (rd_addr),
    .rd_valid           (rd_valid),
    .rd_patch           (rd_patch),
    .mem_csb0           (mem_csb0),
    .mem_web0           (mem_web0),
    .mem_addr0          (mem_addr0),
    .mem_wpatch0        (mem_wpatch0),
    .mem_rpatch0        (mem_rpatch0)
  );

  // Behavioural SRAM: synchronous write, registered read data.
  logic [PW-1:0] sram [0:NQ-1];
  logic [PW-1:0] sram_q = '0;
  assign mem_rpatch0 = sram_q;

  always @(posedge clk) begin
    if (!mem_csb0 && (int'(mem_addr0) < NQ)) begin
      if (!mem_web0) sram[mem_addr0] <= mem_wpatch0;
      else           sram_q <= sram[mem_addr0];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wbs_debug          = 1'b0;
    wbs_qp_mem_csb0    = 1'b1;
    wbs_qp_mem_web0    = 1'b1;
    wbs_qp_mem_addr0   = '0;
    wbs_qp_mem_wpatch0 = '0;
    load_start         = 1'b0;
    patch_valid        = 1'b0;
    patch_in           = '0;
    rd_req             = 1'b0;
    rd_addr            = '0;
  endtask

  // Pulse load_start, then stream n patches (0x100 + addr), leaving the
  // bench 1 ns after the edge that accepted the last one.
  task automatic stream(input int n);
    load_start  = 1'b1;
    patch_valid = 1'b0;
    cyc();
    load_start = 1'b0;
    patch_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      patch_in = PW'(32'h100 + i);
      cyc();
    end
    patch_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (load_done !== 1'b0)   begin failures++; $display("FAIL reset_load_done got=%b exp=0", load_done); end
    checks++; if (rd_valid !== 1'b0)    begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL reset_patch_ready got=%b exp=0", patch_ready); end
    checks++; if ({mem_csb0, mem_web0, mem_addr0} !== {2'b11, 9'd0}) begin failures++; $display("FAIL reset_mem_ctl got=%b%b/%0d exp=11/0", mem_csb0, mem_web0, mem_addr0); end
    #4 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_full_load();
    load_start  = 1'b1;
    patch_valid = 1'b1;
    patch_in    = 55'h100;
    #1;
    checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", patch_ready); end
    cyc();
    load_start = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      patch_in = PW'(32'h100 + i);
      #1;
      checks++;
      if ({mem_csb0, mem_web0, mem_addr0, mem_wpatch0} !== {2'b00, ADDRW'(i), PW'(32'h100 + i)}) begin
        failures++;
        $display("FAIL load_write[%0d] got=%b%b/%0d/%h exp=00/%0d/%h", i, mem_csb0, mem_web0, mem_addr0, mem_wpatch0, i, 32'h100 + i);
      end
      checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL early_done[%0d] got=%b exp=0", i, load_done); end
      @(posedge clk); #1;
    end
    #1;
    checks++; if (load_done !== 1'b1)   begin failures++; $display("FAIL load_done got=%b exp=1", load_done); end
    checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL done_ready got=%b exp=0", patch_ready); end
    checks++; if (mem_csb0 !== 1'b1)    begin failures++; $display("FAIL done_no_write got=%b exp=1", mem_csb0); end
    patch_valid = 1'b0;
    cyc();
    checks++; if (load_done !== 1'b1)   begin failures++; $display("FAIL done_held got=%b exp=1", load_done); end
  endtask

  task automatic test_back_to_back_reads();
    logic [ADDRW-1:0] addrs [4] = '{9'd0, 9'd5, 9'd407, 9'd408};
    logic [PW-1:0]    exps  [3] = '{55'h100, 55'h105, 55'h297};
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = addrs[i];
      #1;
      if (i < 3) begin
        checks++; if ({mem_csb0, mem_web0, mem_addr0} !== {2'b01, addrs[i]}) begin failures++; $display("FAIL rd_issue[%0d] got=%b%b/%0d exp=01/%0d", i, mem_csb0, mem_web0, mem_addr0, addrs[i]); end
      end else begin
        checks++; if (mem_csb0 !== 1'b1) begin failures++; $display("FAIL rd_oob_access got=%b exp=1", mem_csb0); end
      end
      if (i > 0) begin
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL rd_valid[%0d] got=%b exp=1", i - 1, rd_valid); end
        checks++; if (rd_patch !== exps[i-1]) begin failures++; $display("FAIL rd_patch[%0d] got=%h exp=%h", i - 1, rd_patch, exps[i-1]); end
      end
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_oob_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_patch !== '0)   begin failures++; $display("FAIL rd_patch_zero got=%h exp=0", rd_patch); end
    cyc();
  endtask

  task automatic test_debug();
    stream(100);
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL restart_clears_done got=%b exp=0", load_done); end
    patch_valid = 1'b1;
    patch_in    = 55'h164;
    wbs_debug   = 1'b1;
    rd_req      = 1'b1;
    rd_addr     = 9'd3;
    for (int c = 0; c < 10; c++) begin
      wbs_qp_mem_csb0    = (c < 2) ? 1'b0 : 1'b1;
      wbs_qp_mem_web0    = (c == 0) ? 1'b0 : 1'b1;
      wbs_qp_mem_addr0   = (c < 2) ? 9'd2 : 9'd0;
      wbs_qp_mem_wpatch0 = (c == 0) ? BEEF : '0;
      #1;
      checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL dbg_ready[%0d] got=%b exp=0", c, patch_ready); end
      if (c == 0) begin
        checks++; if ({mem_csb0, mem_web0, mem_addr0, mem_wpatch0} !== {2'b00, 9'd2, BEEF}) begin failures++; $display("FAIL dbg_write got=%b%b/%0d/%h exp=00/2/%h", mem_csb0, mem_web0, mem_addr0, mem_wpatch0, BEEF); end
      end else if (c == 1) begin
        checks++; if ({mem_csb0, mem_web0, mem_addr0} !== {2'b01, 9'd2}) begin failures++; $display("FAIL dbg_read got=%b%b/%0d exp=01/2", mem_csb0, mem_web0, mem_addr0); end
      end else if (c == 2) begin
        checks++; if (wbs_qp_mem_rpatch0 !== BEEF) begin failures++; $display("FAIL dbg_rpatch got=%h exp=%h", wbs_qp_mem_rpatch0, BEEF); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL dbg_rd_valid got=%b exp=0", rd_valid); end
      end else begin
        checks++; if (mem_csb0 !== 1'b1) begin failures++; $display("FAIL dbg_idle[%0d] got=%b exp=1", c, mem_csb0); end
      end
      @(posedge clk); #1;
    end
    wbs_debug       = 1'b0;
    wbs_qp_mem_csb0 = 1'b1;
    rd_req          = 1'b0;
    #1;
    checks++; if (patch_ready !== 1'b1) begin failures++; $display("FAIL resume_ready got=%b exp=1", patch_ready); end
    checks++; if ({mem_csb0, mem_web0, mem_addr0, mem_wpatch0} !== {2'b00, 9'd100, 55'h164}) begin failures++; $display("FAIL resume_write got=%b%b/%0d/%h exp=00/100/164", mem_csb0, mem_web0, mem_addr0, mem_wpatch0); end
    cyc();
    patch_valid = 1'b0;
  endtask

  task automatic test_restart_mid_load();
    stream(50);
    patch_valid = 1'b1;
    patch_in    = 55'h7;
    load_start  = 1'b1;
    #1;
    checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL restart_ready got=%b exp=0", patch_ready); end
    checks++; if (mem_csb0 !== 1'b1)    begin failures++; $display("FAIL restart_no_write got=%b exp=1", mem_csb0); end
    cyc();
    load_start = 1'b0;
    #1;
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL restart_done got=%b exp=0", load_done); end
    checks++; if ({mem_csb0, mem_web0, mem_addr0} !== {2'b00, 9'd0}) begin failures++; $display("FAIL restart_addr got=%b%b/%0d exp=00/0", mem_csb0, mem_web0, mem_addr0); end
    cyc();
    patch_valid = 1'b0;
  endtask

  task automatic test_read_during_load();
    rd_req  = 1'b1;
    rd_addr = 9'd5;
    #1;
    checks++; if (mem_csb0 !== 1'b1) begin failures++; $display("FAIL load_rd_access got=%b exp=1", mem_csb0); end
    cyc();
    rd_req = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL load_rd_valid got=%b exp=0", rd_valid); end
    cyc();
  endtask

  task automatic test_reset_mid_stream();
    patch_valid = 1'b1;
    patch_in    = 55'h55;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0", patch_ready); end
    checks++; if ({mem_csb0, mem_web0, mem_addr0, mem_wpatch0} !== {2'b11, 9'd0, 55'd0}) begin failures++; $display("FAIL rst_mid_mem got=%b%b/%0d/%h exp=11/0/0", mem_csb0, mem_web0, mem_addr0, mem_wpatch0); end
    checks++; if ({load_done, rd_valid, rd_patch} !== '0) begin failures++; $display("FAIL rst_mid_outs got=%b%b/%h exp=00/0", load_done, rd_valid, rd_patch); end
    #2 rst_n = 1'b1;
    cyc();
    #1;
    checks++; if (patch_ready !== 1'b0) begin failures++; $display("FAIL rst_idle_ready got=%b exp=0", patch_ready); end
    patch_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_back_to_back_reads();
    test_debug();
    test_restart_mid_load();
    test_read_during_load();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qp_mem_loader.md
Name: qp_mem_loader

Overview:
- Owns the single port of the query-patch SRAM; sits between the query-patch stream, the accelerator read path, and the Wishbone controller's debug memory port.
- Normal mode: streams NUM_QUERYS patches into consecutive SRAM addresses, then serves single-cycle-issue reads to the search datapath.
- Debug mode (wbs_debug=1): the Wishbone controller's SRAM signals pass straight through and all internal traffic is stalled.

Parameters:
- DATA_WIDTH, 11, bits per patch element
- PATCH_SIZE, 5, elements per patch; patch width PW = PATCH_SIZE*DATA_WIDTH = 55
- ROW_SIZE, 24, query rows
- COL_SIZE, 17, query columns
- NUM_QUERYS, ROW_SIZE*COL_SIZE = 408, SRAM depth
- ADDRW, $clog2(NUM_QUERYS) = 9, address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wbs_debug  in  1  debug override from Wishbone controller
- wbs_qp_mem_csb0  in  1  debug chip select, active low
- wbs_qp_mem_web0  in  1  debug write enable, active low
- wbs_qp_mem_addr0  in  ADDRW  debug address
- wbs_qp_mem_wpatch0  in  PW  debug write data
- wbs_qp_mem_rpatch0  out  PW  debug read data
- load_start  in  1  pulse; starts or restarts a load
- patch_valid  in  1  stream valid
- patch_in  in  PW  stream patch
- patch_ready  out  1  stream ready
- load_done  out  1  all NUM_QUERYS patches written
- rd_req  in  1  accelerator read request
- rd_addr  in  ADDRW  accelerator read address
- rd_valid  out  1  rd_patch valid
- rd_patch  out  PW  accelerator read data
- mem_csb0  out  1  SRAM chip select, active low
- mem_web0  out  1  SRAM write enable, active low
- mem_addr0  out  ADDRW  SRAM address
- mem_wpatch0  out  PW  SRAM write data
- mem_rpatch0  in  PW  SRAM read data, valid the cycle after a read issue

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wr_cnt=0, load_done=0, rd_valid=0.
  - Registered outputs clear immediately.
- States:
  - IDLE: load_start -> LOAD.
  - LOAD: the accepted write at wr_cnt=NUM_QUERYS-1 -> DONE.
  - DONE: load_start -> LOAD.
  - load_start in any state clears wr_cnt to 0 and load_done to 0.
- patch_ready = (state==LOAD) & ~wbs_debug & ~load_start.
- Write handshake (patch_valid & patch_ready):
  - Same cycle: mem_csb0=0, mem_web0=0, mem_addr0=wr_cnt, mem_wpatch0=patch_in.
  - wr_cnt increments at the clock edge.
- load_done: registered; rises the cycle after the last write; held in DONE.
- Reads:
  - Accepted only when state is IDLE or DONE, wbs_debug=0, and rd_addr < NUM_QUERYS.
  - Issue: mem_csb0=0, mem_web0=1, mem_addr0=rd_addr.
  - rd_valid=1 exactly one cycle later, with rd_patch = mem_rpatch0 (combinational pass of the SRAM output).
  - Reads are pipelined: back-to-back rd_req gives back-to-back rd_valid.
- Dropped reads: rd_req during LOAD, during debug, or with an out-of-range address produces no rd_valid and no SRAM access.
- rd_patch = 0 whenever rd_valid = 0.
- Debug (wbs_debug=1):
  - mem_* = wbs_qp_mem_* combinationally.
  - wbs_qp_mem_rpatch0 = mem_rpatch0 always (no gating).
  - State and wr_cnt are frozen; the load resumes at the same address when debug deasserts.
  - A read issued the cycle before debug asserts still completes rd_valid.
- No access in a cycle: mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0.
- Priority (highest first): debug > load write > accelerator read.
- Boundaries:
  - wr_cnt never exceeds NUM_QUERYS-1; patch_ready=0 in DONE.
  - Reset mid-load discards progress.

Test Plan:
- Reset mid-stream -> all outputs 0 (mem_csb0/web0 = 1) asynchronously, before the next clk edge.
- load_start, then stream 408 patches with patch_in = address+0x100, patch_valid held 1 -> 408 writes to addresses 0..407, load_done=1 the cycle after the 408th write, patch_ready=0 afterwards.
- After load, rd_req at addresses 0, 5, 407 on consecutive cycles with a model SRAM -> rd_valid on 3 consecutive cycles, rd_patch = 0x100, 0x105, 0x297; rd_req at address 408 -> no rd_valid.
- wbs_debug=1 at wr_cnt=100 for 10 cycles while a Wishbone read hits addr 2 (SRAM returns 55'h00_1010_DEAD_BEEF) -> mem_addr0=2, wbs_qp_mem_rpatch0 = 55'h00_1010_DEAD_BEEF, patch_ready=0; after release the next write goes to address 100.
- load_start pulsed at wr_cnt=50 -> patch_ready=0 that cycle, load_done=0, next write at address 0.
- rd_req during LOAD -> no SRAM read and no rd_valid.
